// File: rtl/io_bus_if.sv
// io_bus_if: bundle for the 8-bit CPU peripheral bus between the core-side
// request/response port and the peripheral strobes.
//   req_*  : core request (valid/ready handshake, we, addr, wdata)
//   rsp_*  : one-cycle response pulse (valid, rdata, err), no backpressure
//   bus_*  : peripheral side (shared addr/din, per-slave wr/rd strobes,
//            concatenated per-slave read data, slave k on [8k+7:8k])
// Modports: master = io_bus_master view, slave = core + peripherals view.
interface io_bus_if #(
  parameter int NUM_SLAVES = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [7:0]                req_addr;
  logic [7:0]                req_wdata;
  logic                      rsp_valid;
  logic [7:0]                rsp_rdata;
  logic                      rsp_err;
  logic [7:0]                bus_addr;
  logic [7:0]                bus_din;
  logic [NUM_SLAVES-1:0]     bus_wr_en;
  logic [NUM_SLAVES-1:0]     bus_rd_en;
  logic [8*NUM_SLAVES-1:0]   bus_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, bus_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_addr, bus_din, bus_wr_en, bus_rd_en
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, bus_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_addr, bus_din, bus_wr_en, bus_rd_en
  );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master: initiator for the 8-bit peripheral bus. Accepts one
// read/write request at a time, decodes addr[7:SEL_LSB] into a per-slave
// single-cycle strobe, waits RD_LATENCY cycles for read data and returns a
// one-cycle response (rsp_err for unmapped slots).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : io_bus_if.master (request, response and peripheral signals)
module io_bus_master #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset,
  io_bus_if.master  bus
);

  localparam int IDX_W = 8 - SEL_LSB;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic                  we_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [2:0]            cnt;

  logic [IDX_W-1:0]      req_idx;
  logic [NUM_SLAVES-1:0] req_sel;
  logic [7:0]            sel_dout;

  assign req_idx = bus.req_addr[7:SEL_LSB];

  // One-hot slot decode of the incoming address; all-zero means unmapped.
  always_comb begin
    req_sel = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++)
      req_sel[k] = (req_idx == IDX_W'(k));
  end

  // Read-data mux over the latched slot index.
  always_comb begin
    sel_dout = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++)
      if (idx_q == IDX_W'(k))
        sel_dout = bus.bus_dout[8*k +: 8];
  end

  assign bus.req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      idx_q         <= '0;
      cnt           <= '0;
      bus.bus_addr  <= '0;
      bus.bus_din   <= '0;
      bus.bus_wr_en <= '0;
      bus.bus_rd_en <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q         <= bus.req_we;
            err_q        <= ~|req_sel;
            idx_q        <= req_idx;
            bus.bus_addr <= bus.req_addr;
            bus.bus_din  <= bus.req_wdata;
            // Strobe is registered on the accept edge so it is high exactly
            // during the ISSUE cycle, alongside the latched addr/din.
            if (bus.req_we)
              bus.bus_wr_en <= req_sel;
            else
              bus.bus_rd_en <= req_sel;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.bus_wr_en <= '0;
          bus.bus_rd_en <= '0;
          if (err_q) begin
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (we_q) begin
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt   <= 3'(RD_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          // Last step: slave dout is valid in this cycle, capture it.
          if (cnt == 3'd1) begin
            bus.rsp_rdata <= sel_dout;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: two instances (RD_LATENCY=1 and 3) with
// small behavioural slave models; checks strobes, hold, latency and reset.
module tb_io_bus_master;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  io_bus_if #(.NUM_SLAVES(4)) bus0 ();
  io_bus_if #(.NUM_SLAVES(4)) bus3 ();

  io_bus_master #(.NUM_SLAVES(4), .SEL_LSB(4), .RD_LATENCY(1)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0)
  );
  io_bus_master #(.NUM_SLAVES(4), .SEL_LSB(4), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(bus3)
  );

  // Slave 2 of dut0: registered read, data valid for one cycle after rd_en.
  logic [7:0] s2_dout = 8'h00;
  always @(posedge clk) s2_dout <= bus0.bus_rd_en[2] ? 8'h3C : 8'h00;
  assign bus0.bus_dout = {8'hD3, s2_dout, 8'hB1, 8'hA0};

  // Slave 3 of dut3: 0x77 two cycles after rd_en, 0x99 three cycles after.
  logic [2:0] dly = 3'd0;
  logic [7:0] s3_dout;
  always @(posedge clk) begin
    if (bus3.bus_rd_en[3]) dly <= 3'd1;
    else if (dly != 3'd0 && dly != 3'd7) dly <= dly + 3'd1;
  end
  assign s3_dout = (dly == 3'd3) ? 8'h99 : (dly == 3'd2) ? 8'h77 : 8'h00;
  assign bus3.bus_dout = {s3_dout, 8'hC2, 8'hC1, 8'hC0};

  // Write log of slave 1 on dut0.
  logic [7:0] log_addr [3];
  logic [7:0] log_din  [3];
  int         log_n = 0;
  always @(posedge clk) begin
    if (bus0.bus_wr_en[1]) begin
      if (log_n < 3) begin
        log_addr[log_n] <= bus0.bus_addr;
        log_din[log_n]  <= bus0.bus_din;
      end
      log_n <= log_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus0.req_valid = v;
    bus0.req_we    = we;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
  endtask

  initial begin
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    bus3.req_valid = 1'b0;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = 8'h00;
    bus3.req_wdata = 8'h00;

    // Reset, with a request held during reset that must not be accepted.
    tick();
    drive0(1'b1, 1'b1, 8'h01, 8'h5A);
    tick();
    chk("rst_ready0", bus0.req_ready, 1'b0);
    chk("rst_ready3", bus3.req_ready, 1'b0);
    chk("rst_wr_en", bus0.bus_wr_en, 4'b0000);
    chk("rst_rd_en", bus0.bus_rd_en, 4'b0000);
    chk("rst_addr", bus0.bus_addr, 8'h00);
    chk("rst_din", bus0.bus_din, 8'h00);
    chk("rst_rsp", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, 10'h000);
    rst0 = 1'b0;
    rst3 = 1'b0;
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("rst_win_wr_en", bus0.bus_wr_en, 4'b0000);
    chk("post_rst_ready0", bus0.req_ready, 1'b1);
    chk("post_rst_ready3", bus3.req_ready, 1'b1);
    tick();
    chk("rst_win_rsp", bus0.rsp_valid, 1'b0);

    // Write 0x01 <- 0xA5.
    drive0(1'b1, 1'b1, 8'h01, 8'hA5);
    tick();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    chk("wr_strobe", bus0.bus_wr_en, 4'b0001);
    chk("wr_rd_en", bus0.bus_rd_en, 4'b0000);
    chk("wr_addr", bus0.bus_addr, 8'h01);
    chk("wr_din", bus0.bus_din, 8'hA5);
    chk("wr_ready_issue", bus0.req_ready, 1'b0);
    chk("wr_rsp_early", bus0.rsp_valid, 1'b0);
    tick();
    chk("wr_rsp", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, 10'h200);
    chk("wr_strobe_drop", bus0.bus_wr_en, 4'b0000);
    chk("wr_addr_hold", bus0.bus_addr, 8'h01);
    tick();
    chk("wr_rsp_end", bus0.rsp_valid, 1'b0);
    chk("wr_ready_back", bus0.req_ready, 1'b1);
    chk("wr_addr_idle", bus0.bus_addr, 8'h01);

    // Read 0x22 from slave 2.
    drive0(1'b1, 1'b0, 8'h22, 8'h00);
    tick();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    chk("rd_strobe", bus0.bus_rd_en, 4'b0100);
    chk("rd_wr_en", bus0.bus_wr_en, 4'b0000);
    tick();
    chk("rd_wait_rsp", bus0.rsp_valid, 1'b0);
    chk("rd_wait_strobe", bus0.bus_rd_en, 4'b0000);
    chk("rd_wait_ready", bus0.req_ready, 1'b0);
    tick();
    chk("rd_rsp", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, 10'h23C);
    tick();
    chk("rd_rsp_end", bus0.rsp_valid, 1'b0);
    chk("rd_ready_back", bus0.req_ready, 1'b1);

    // Unmapped read 0x50.
    drive0(1'b1, 1'b0, 8'h50, 8'h00);
    tick();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    chk("um_strobes", {bus0.bus_wr_en, bus0.bus_rd_en}, 8'h00);
    chk("um_addr", bus0.bus_addr, 8'h50);
    tick();
    chk("um_rsp", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, 10'h300);
    chk("um_strobes2", {bus0.bus_wr_en, bus0.bus_rd_en}, 8'h00);
    tick();
    chk("um_rsp_end", {bus0.rsp_valid, bus0.rsp_err}, 2'b00);
    chk("um_ready_back", bus0.req_ready, 1'b1);

    // Three back-to-back writes to slave 1 with req_valid held high.
    drive0(1'b1, 1'b1, 8'h10, 8'h11);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("b2b_wr_en_c%0d", c), bus0.bus_wr_en,
          (c == 1 || c == 4 || c == 7) ? 4'b0010 : 4'b0000);
      chk($sformatf("b2b_ready_c%0d", c), bus0.req_ready, (c % 3 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("b2b_rsp_c%0d", c), bus0.rsp_valid, (c % 3 == 2) ? 1'b1 : 1'b0);
      if (c == 1) drive0(1'b1, 1'b1, 8'h11, 8'h22);
      if (c == 4) drive0(1'b1, 1'b1, 8'h12, 8'h33);
      if (c == 7) drive0(1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk("b2b_count", log_n, 3);
    chk("b2b_0", {log_addr[0], log_din[0]}, 16'h1011);
    chk("b2b_1", {log_addr[1], log_din[1]}, 16'h1122);
    chk("b2b_2", {log_addr[2], log_din[2]}, 16'h1233);

    // Reset asserted in WAIT of a read: no response, back to IDLE.
    drive0(1'b1, 1'b0, 8'h22, 8'h00);
    tick();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    chk("ab_strobe", bus0.bus_rd_en, 4'b0100);
    tick();
    rst0 = 1'b1;
    tick();
    chk("ab_rsp", bus0.rsp_valid, 1'b0);
    chk("ab_strobes", {bus0.bus_wr_en, bus0.bus_rd_en}, 8'h00);
    chk("ab_ready_in_rst", bus0.req_ready, 1'b0);
    rst0 = 1'b0;
    tick();
    chk("ab_ready", bus0.req_ready, 1'b1);
    chk("ab_rsp2", bus0.rsp_valid, 1'b0);

    // RD_LATENCY=3 read from slave 3.
    bus3.req_valid = 1'b1;
    bus3.req_addr  = 8'h33;
    tick();
    bus3.req_valid = 1'b0;
    chk("l3_strobe", bus3.bus_rd_en, 4'b1000);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("l3_wait_c%0d", c), bus3.rsp_valid, 1'b0);
      chk($sformatf("l3_strobe_c%0d", c), bus3.bus_rd_en, 4'b0000);
    end
    tick();
    chk("l3_rsp", {bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata}, 10'h299);
    tick();
    chk("l3_rsp_end", bus3.rsp_valid, 1'b0);
    chk("l3_ready", bus3.req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
